// File: rtl/nibble_addsub_seq.sv
// nibble_addsub_seq
// Sequential W = 4*NIBBLES bit adder/subtractor built around one 4-bit slice.
// Operands are latched on start and processed one nibble per clock, LSB first.
// The nibble carry is held in a register between slices. done pulses for one
// cycle when result and the carry/overflow flags are valid.
// Optional feature: define NIBBLE_SEQ_SAT_EN to clamp the result on signed
// overflow. The flags still report the unclamped outcome.

module nibble_addsub_seq #(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         overflow,
    output logic         zero
);

    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [NIBBLES-1:0][3:0] r_a;
    logic [NIBBLES-1:0][3:0] r_b;
    logic [NIBBLES-1:0][3:0] r_result;
    logic                    r_sub;
    logic                    r_c;
    logic                    r_carry;
    logic                    r_ovf;
    logic [IW-1:0]           r_idx;

    logic [3:0]              w_a_nib;
    logic [3:0]              w_b_nib;
    logic [4:0]              w_sum;
    logic                    w_last;
    logic                    w_accept;
    logic                    w_ovf;

    // A new operation is taken whenever the sequencer is not mid-run.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_idx == IW'(NIBBLES - 1));

    // One 4-bit add/sub slice; subtraction is a + ~b + 1 with the +1 seeded in r_c.
    always_comb begin
        w_a_nib = r_a[r_idx];
        w_b_nib = r_b[r_idx] ^ {4{r_sub}};
        w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_c};
        // Only meaningful on the MSB nibble: operand signs agree, result sign differs.
        w_ovf   = (r_a[NIBBLES-1][3] == w_b_nib[3]) && (w_sum[3] != r_a[NIBBLES-1][3]);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start is ignored while running; DONE may chain straight into RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, nibble index, inter-nibble carry, result and final flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_c      <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sub <= op_sub;
            r_c   <= op_sub;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_result[r_idx] <= w_sum[3:0];
            r_c             <= w_sum[4];
            if (w_last) begin
                r_idx   <= '0;
                r_carry <= w_sum[4];
                r_ovf   <= w_ovf;
`ifdef NIBBLE_SEQ_SAT_EN
                // Clamp overrides the final nibble write in the same cycle.
                if (w_ovf) begin
                    if (r_a[NIBBLES-1][3]) begin
                        r_result <= {1'b1, {(W-1){1'b0}}};
                    end else begin
                        r_result <= {1'b0, {(W-1){1'b1}}};
                    end
                end
`endif
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign zero     = ~|r_result;

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Testbench for nibble_addsub_seq (NIBBLES=4, 16-bit operands).
// Expected results are queued when an operation is started and popped on done.

module tb_nibble_addsub_seq;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_overlap = 0;
    res_t sb[$];

    nibble_addsub_seq #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) n_overlap++;
    end

    // Independent full-width reference for random operations.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] yy;
        logic [16:0] t;
        res_t        e;
        yy  = s ? ~y : y;
        t   = {1'b0, x} + {1'b0, yy} + {16'h0000, s};
        e.r = t[15:0];
        e.c = t[16];
        e.v = (x[15] == yy[15]) && (t[15] != x[15]);
`ifdef NIBBLE_SEQ_SAT_EN
        if (e.v) e.r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        e.z = (e.r == 16'h0000);
        return e;
    endfunction

    // Drive one start pulse (sampled at the next edge) and queue its expectation.
    task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic s, input res_t e);
        a = x; b = y; op_sub = s; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done with a bound; returns observed outputs and edges waited.
    task automatic wait_done(output res_t got, output int lat, output bit to);
        got = '0; lat = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                got = {result, carry, overflow, zero};
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [20:0] obs;
        obs = {busy, done, result, carry, overflow, zero};
        n_cmp++;
        if (obs !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected %h", obs, {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_directed(input string name, input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input res_t e);
        res_t got, exp;
        int   lat;
        bit   to;
        start_op(x, y, s, e);
        wait_done(got, lat, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end else if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got r=%h c=%b v=%b z=%b expected r=%h c=%b v=%b z=%b",
                     name, got.r, got.c, got.v, got.z, exp.r, exp.c, exp.v, exp.z);
        end
        n_cmp++;
        if (lat !== N) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, N);
        end
    endtask

    task automatic test_ignore_start;
        res_t got, exp;
        int   lat, pulses;
        bit   to;
        start_op(16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(got, lat, to);
        exp = sb.pop_front();
        n_cmp++;
        if (to || got !== exp) begin
            n_bad++;
            $display("FAIL ignore_start: got r=%h c=%b v=%b z=%b to=%b expected r=%h c=%b v=%b z=%b",
                     got.r, got.c, got.v, got.z, to, exp.r, exp.c, exp.v, exp.z);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL ignore_start_no_second_op: got %0d active cycles expected 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        res_t got, exp;
        int   lat;
        bit   to;
        logic [15:0] xs [3] = '{16'h00FF, 16'h4000, 16'h0F0F};
        logic [15:0] ys [3] = '{16'h0001, 16'h4000, 16'h0F0F};
        logic        ss [3] = '{1'b0, 1'b0, 1'b1};
        res_t        es [3] = '{'{16'h0100, 1'b0, 1'b0, 1'b0},
`ifdef NIBBLE_SEQ_SAT_EN
                                '{16'h7FFF, 1'b0, 1'b1, 1'b0},
`else
                                '{16'h8000, 1'b0, 1'b1, 1'b0},
`endif
                                '{16'h0000, 1'b1, 1'b0, 1'b1}};
        n_overlap = 0;
        a = xs[0]; b = ys[0]; op_sub = ss[0]; start = 1'b1;
        sb.push_back(es[0]);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            wait_done(got, lat, to);
            if (k < 2) begin
                a = xs[k+1]; b = ys[k+1]; op_sub = ss[k+1];
                sb.push_back(es[k+1]);
            end else begin
                start = 1'b0;
            end
            exp = sb.pop_front();
            n_cmp++;
            if (to || got !== exp) begin
                n_bad++;
                $display("FAIL b2b_result%0d: got r=%h c=%b v=%b z=%b to=%b expected r=%h c=%b v=%b z=%b",
                         k, got.r, got.c, got.v, got.z, to, exp.r, exp.c, exp.v, exp.z);
            end
            n_cmp++;
            if (lat !== ((k == 0) ? N : N + 1)) begin
                n_bad++;
                $display("FAIL b2b_period%0d: got %0d expected %0d", k, lat, (k == 0) ? N : N + 1);
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (n_overlap !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_busy_done_overlap: got overlap=%0d busy=%b expected 0 and 0", n_overlap, busy);
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] obs;
        int          act;
        a = 16'hAAAA; b = 16'h5555; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        obs = {busy, done, result, zero};
        n_cmp++;
        if (obs !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid: got %h expected %h", obs, {1'b0, 1'b0, 16'h0000, 1'b1});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) act++;
        end
        n_cmp++;
        if (act !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", act);
        end
        test_directed("after_reset", 16'h0123, 16'h0456, 1'b0, '{16'h0579, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_random;
        res_t got, exp;
        int   lat;
        bit   to;
        logic [15:0] x, y;
        logic        s;
        for (int i = 0; i < 24; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'($urandom);
            start_op(x, y, s, model(x, y, s));
            wait_done(got, lat, to);
            exp = sb.pop_front();
            n_cmp++;
            if (to || got !== exp) begin
                n_bad++;
                $display("FAIL random%0d %h %s %h: got r=%h c=%b v=%b z=%b to=%b expected r=%h c=%b v=%b z=%b",
                         i, x, s ? "-" : "+", y, got.r, got.c, got.v, got.z, to, exp.r, exp.c, exp.v, exp.z);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed("add", 16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0});
`ifdef NIBBLE_SEQ_SAT_EN
        test_directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, '{16'h8000, 1'b1, 1'b1, 1'b0});
        test_directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0});
`else
        test_directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0});
        test_directed("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0});
`endif
        test_directed("wrap_zero", 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1});
        test_directed("sub_equal", 16'h0005, 16'h0005, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1});
        test_directed("sub_borrow", 16'h0003, 16'h0005, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0});
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
